// File: rtl/mix_add_arbiter.sv
// Round-robin sequencer sharing one external mix adder between NUM_REQ requesters.
// Each granted operand pair goes through the adder once; the sum is returned with the requester id.
module mix_add_arbiter #(
   parameter int WIDTH   = 8,
   parameter int NUM_REQ = 4,
   localparam int ID_W   = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] opa,
   input  logic [NUM_REQ*WIDTH-1:0] opb,
   output logic [NUM_REQ-1:0]       gnt,
   output logic [WIDTH-1:0]         mix_comb_in,
   output logic [WIDTH-1:0]         mix_comb_add,
   input  logic [WIDTH-1:0]         mix_comb_out,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic [WIDTH-1:0]         rsp_data,
   output logic                     busy,
   output logic [15:0]              op_cnt,
   output logic [1:0]               dbg_state,
   output logic [ID_W-1:0]          dbg_ptr
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [WIDTH-1:0]   in_q, in_d;
   logic [WIDTH-1:0]   add_q, add_d;
   logic               valid_q, valid_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [15:0]        cnt_q, cnt_d;

   logic               found;
   logic [ID_W-1:0]    win_id;
   logic [ID_W-1:0]    scan_idx;

   // First requester at or after ptr_q, wrapping modulo NUM_REQ.
   always_comb begin
      found    = 1'b0;
      win_id   = '0;
      scan_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_idx = ID_W'((int'(ptr_q) + i) % NUM_REQ);
         if (!found && req[scan_idx]) begin
            found  = 1'b1;
            win_id = scan_idx;
         end
      end
   end

   // Response channel: a transfer happens on a clock edge where rsp_valid and rsp_ready
   // are both high; while rsp_valid is high without rsp_ready, id and data stay frozen.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = '0;
      in_d    = in_q;
      add_d   = add_q;
      valid_d = valid_q;
      id_d    = id_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               gnt_d[win_id] = 1'b1;
               in_d          = opa[win_id*WIDTH +: WIDTH];
               add_d         = opb[win_id*WIDTH +: WIDTH];
               id_d          = win_id;
               state_d       = ISSUE;
            end
         end
         ISSUE: begin
            data_d  = mix_comb_out;
            valid_d = 1'b1;
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               valid_d = 1'b0;
               ptr_d   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
               cnt_d   = cnt_q + 16'd1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gnt_q   <= '0;
         in_q    <= '0;
         add_q   <= '0;
         valid_q <= 1'b0;
         id_q    <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         in_q    <= in_d;
         add_q   <= add_d;
         valid_q <= valid_d;
         id_q    <= id_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   assign gnt          = gnt_q;
   assign mix_comb_in  = in_q;
   assign mix_comb_add = add_q;
   assign rsp_valid    = valid_q;
   assign rsp_id       = id_q;
   assign rsp_data     = data_q;
   assign busy         = (state_q != IDLE);
   assign op_cnt       = cnt_q;
   assign dbg_state    = state_q;
   assign dbg_ptr      = ptr_q;

endmodule

// File: tb/tb_mix_add_arbiter.sv
// Bench for mix_add_arbiter: vector table, reset/back-pressure sequences and a random run,
// with responses checked against an expected queue of {id, sum}.
module tb_mix_add_arbiter;

   localparam int WIDTH   = 8;
   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   logic                     clk = 1'b0;
   logic                     rst = 1'b0;
   logic [NUM_REQ-1:0]       req = '0;
   logic [NUM_REQ*WIDTH-1:0] opa = '0;
   logic [NUM_REQ*WIDTH-1:0] opb = '0;
   logic [NUM_REQ-1:0]       gnt;
   logic [WIDTH-1:0]         mix_comb_in;
   logic [WIDTH-1:0]         mix_comb_add;
   logic [WIDTH-1:0]         mix_comb_out;
   logic                     rsp_valid;
   logic                     rsp_ready = 1'b0;
   logic [ID_W-1:0]          rsp_id;
   logic [WIDTH-1:0]         rsp_data;
   logic                     busy;
   logic [15:0]              op_cnt;
   logic [1:0]               dbg_state;
   logic [ID_W-1:0]          dbg_ptr;

   int n_vec = 0;
   int n_err = 0;
   int model_cnt = 0;
   logic [ID_W-1:0] model_ptr = '0;
   logic [ID_W+WIDTH-1:0] exp_q[$];

   typedef struct {
      logic [NUM_REQ-1:0]       req;
      logic [NUM_REQ*WIDTH-1:0] opa;
      logic [NUM_REQ*WIDTH-1:0] opb;
      int                       dly;
      logic [ID_W-1:0]          exp_id;
      logic [WIDTH-1:0]         exp_data;
   } vec_t;

   vec_t tbl[11];

   mix_add_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .opa          (opa),
      .opb          (opb),
      .gnt          (gnt),
      .mix_comb_in  (mix_comb_in),
      .mix_comb_add (mix_comb_add),
      .mix_comb_out (mix_comb_out),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_id       (rsp_id),
      .rsp_data     (rsp_data),
      .busy         (busy),
      .op_cnt       (op_cnt),
      .dbg_state    (dbg_state),
      .dbg_ptr      (dbg_ptr)
   );

   // Model of the shared mix adder: carry discarded.
   assign mix_comb_out = mix_comb_in + mix_comb_add;

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every accepted response is popped and compared.
   always @(negedge clk) begin
      if (rst && rsp_valid && rsp_ready) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL rsp_unexpected: got id %0d data %0d with empty queue", rsp_id, rsp_data);
         end else begin
            logic [ID_W+WIDTH-1:0] e;
            e = exp_q.pop_front();
            if ({rsp_id, rsp_data} !== e) begin
               n_err++;
               $display("FAIL rsp_sb: got id %0d data %0d expected id %0d data %0d",
                        rsp_id, rsp_data, e[WIDTH+:ID_W], e[WIDTH-1:0]);
            end
         end
      end
   end

   function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [ID_W-1:0] p);
      logic [ID_W-1:0] c;
      rr_pick = p;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         c = ID_W'((int'(p) + k) % NUM_REQ);
         if (r[c]) rr_pick = c;
      end
   endfunction

   // Driver: starts in IDLE just after a rising edge, ends in IDLE just after a rising edge.
   task automatic do_txn(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ*WIDTH-1:0] a,
                         input logic [NUM_REQ*WIDTH-1:0] b, input int dly,
                         input logic [ID_W-1:0] eid, input logic [WIDTH-1:0] edata,
                         output logic [ID_W-1:0] got_id);
      logic [WIDTH-1:0] ea, eb;
      logic [NUM_REQ-1:0] eg;
      ea = a[eid*WIDTH +: WIDTH];
      eb = b[eid*WIDTH +: WIDTH];
      eg = '0;
      eg[eid] = 1'b1;
      req = r; opa = a; opb = b; rsp_ready = (dly == 0);
      exp_q.push_back({eid, edata});
      @(posedge clk); @(negedge clk);
      check("gnt_issue", gnt, eg);
      check("comb_in", mix_comb_in, ea);
      check("comb_add", mix_comb_add, eb);
      check("busy_issue", busy, 1);
      check("valid_issue", rsp_valid, 0);
      @(posedge clk); #1;
      req = '0; opa = $urandom; opb = $urandom;
      @(negedge clk);
      got_id = rsp_id;
      check("gnt_pulse", gnt, 0);
      check("valid_resp", rsp_valid, 1);
      check("id_resp", rsp_id, eid);
      check("data_resp", rsp_data, edata);
      if (dly > 0) begin
         req = '1;
         for (int d = 1; d < dly; d++) begin
            @(posedge clk); @(negedge clk);
            check("stall_valid", rsp_valid, 1);
            check("stall_id", rsp_id, eid);
            check("stall_data", rsp_data, edata);
            check("stall_gnt", gnt, 0);
            check("stall_busy", busy, 1);
         end
         @(posedge clk); #1;
         rsp_ready = 1'b1;
      end
      @(posedge clk); #1;
      req = '0;
      model_cnt++;
      model_ptr = (eid == ID_W'(NUM_REQ - 1)) ? '0 : eid + ID_W'(1);
      check("idle_busy", busy, 0);
      check("idle_valid", rsp_valid, 0);
      check("idle_state", dbg_state, 0);
      check("op_cnt", op_cnt, model_cnt);
      check("ptr", dbg_ptr, model_ptr);
   endtask

   initial begin
      logic [ID_W-1:0] got;
      logic [NUM_REQ-1:0] r;
      logic [NUM_REQ*WIDTH-1:0] a, b;
      logic [ID_W-1:0] eid;
      int waits[NUM_REQ];
      int max_wait;
      int done;

      tbl[0]  = '{4'b0001, 32'h0000_003A, 32'h0000_0051, 0, 2'd0, 8'd139};
      tbl[1]  = '{4'b0100, 32'h00C8_0000, 32'h0064_0000, 0, 2'd2, 8'd44};
      tbl[2]  = '{4'b1000, 32'hFF00_0000, 32'h0100_0000, 1, 2'd3, 8'd0};
      tbl[3]  = '{4'b1111, 32'h4030_2010, 32'h0403_0201, 0, 2'd0, 8'd17};
      tbl[4]  = '{4'b1111, 32'h4030_2010, 32'h0403_0201, 0, 2'd1, 8'd34};
      tbl[5]  = '{4'b1111, 32'h4030_2010, 32'h0403_0201, 0, 2'd2, 8'd51};
      tbl[6]  = '{4'b1111, 32'h4030_2010, 32'h0403_0201, 0, 2'd3, 8'd68};
      tbl[7]  = '{4'b1111, 32'h4030_2010, 32'h0403_0201, 0, 2'd0, 8'd17};
      tbl[8]  = '{4'b0101, 32'h5507_AA33, 32'h6609_BB44, 5, 2'd2, 8'd16};
      tbl[9]  = '{4'b0011, 32'hDEAD_BE80, 32'h1234_5680, 2, 2'd0, 8'd0};
      tbl[10] = '{4'b1001, 32'h6412_3456, 32'h1BAB_CDEF, 0, 2'd3, 8'd127};

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_gnt", gnt, 0);
      check("rst_valid", rsp_valid, 0);
      check("rst_data", rsp_data, 0);
      check("rst_cnt", op_cnt, 0);
      check("rst_state", dbg_state, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // idle with no request
      @(negedge clk);
      check("idle_no_gnt", gnt, 0);
      check("idle_no_busy", busy, 0);
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++)
         do_txn(tbl[i].req, tbl[i].opa, tbl[i].opb, tbl[i].dly, tbl[i].exp_id, tbl[i].exp_data, got);

      // reset while a response is pending
      req = 4'b0100; opa = 32'h0102_0304; opb = 32'h0506_0708; rsp_ready = 1'b0;
      @(posedge clk); @(negedge clk);
      check("rmid_gnt", gnt, 4'b0100);
      @(posedge clk); @(negedge clk);
      check("rmid_valid", rsp_valid, 1);
      @(posedge clk); #1;
      rst = 1'b0; rsp_ready = 1'b1; req = '0;
      @(posedge clk); #1;
      check("rmid_state", dbg_state, 0);
      check("rmid_ptr", dbg_ptr, 0);
      check("rmid_valid0", rsp_valid, 0);
      check("rmid_id", rsp_id, 0);
      check("rmid_data", rsp_data, 0);
      check("rmid_in", mix_comb_in, 0);
      check("rmid_add", mix_comb_add, 0);
      check("rmid_cnt", op_cnt, 0);
      rst = 1'b1; rsp_ready = 1'b0;
      model_cnt = 0; model_ptr = '0;
      @(posedge clk); #1;
      do_txn(4'b0010, 32'h0000_2100, 32'h0000_0F00, 0, 2'd1, 8'h30, got);

      // random run with starvation tracking on the observed winners
      for (int i = 0; i < NUM_REQ; i++) waits[i] = 0;
      max_wait = 0;
      done = 0;
      for (int it = 0; it < 80 && done < 30; it++) begin
         r = NUM_REQ'($urandom_range(0, 15));
         if (r == '0) begin
            req = '0;
            @(posedge clk); @(negedge clk);
            check("rand_idle_gnt", gnt, 0);
            @(posedge clk); #1;
         end else begin
            a = $urandom; b = $urandom;
            eid = rr_pick(r, model_ptr);
            do_txn(r, a, b, $urandom_range(0, 3), eid,
                   a[eid*WIDTH +: WIDTH] + b[eid*WIDTH +: WIDTH], got);
            for (int i = 0; i < NUM_REQ; i++) begin
               if (r[i] && (ID_W'(i) != got)) waits[i]++;
               else waits[i] = 0;
               if (waits[i] > max_wait) max_wait = waits[i];
            end
            done++;
         end
      end
      check("rand_count", done, 30);
      check("no_starvation", (max_wait < NUM_REQ), 1);

      repeat (2) @(posedge clk);
      #1;
      check("sb_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
